// File: rtl/shake_absorb_pad_pkg.sv
// Shared constants, FSM state type and rate lookup for the SHAKE absorb/pad block.
package shake_pkg;

  localparam logic [4:0] SHAKE128_RATE_WORDS = 5'd21;
  localparam logic [4:0] SHAKE256_RATE_WORDS = 5'd17;
  localparam logic [7:0] PAD_DOMAIN          = 8'h1F;
  localparam logic [7:0] PAD_FINAL           = 8'h80;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  function automatic logic [4:0] rate_words(input logic mode);
    return mode ? SHAKE256_RATE_WORDS : SHAKE128_RATE_WORDS;
  endfunction

endpackage

// File: rtl/shake_absorb_pad_pad_word_gen.sv
// Masks a message word to its valid bytes and ORs in the SHAKE domain byte
// and, for the last rate word, the final 0x80 bit.
module pad_word_gen
  import shake_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [3:0]  bytes_i,
  input  logic        is_last_rate_word_i,
  input  logic        insert_domain_i,
  output logic [63:0] word_o
);

  logic [3:0] nbytes_s;

  // Byte-lane masking and pad insertion; counts above 8 act as a full word.
  always_comb begin
    nbytes_s = (bytes_i > 4'd8) ? 4'd8 : bytes_i;
    word_o   = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes_s) begin
        word_o[8*k +: 8] = word_i[8*k +: 8];
      end else if (insert_domain_i && (4'(k) == nbytes_s)) begin
        word_o[8*k +: 8] = PAD_DOMAIN;
      end else begin
        word_o[8*k +: 8] = 8'h00;
      end
    end
    word_o[63:56] = word_o[63:56] | (is_last_rate_word_i ? PAD_FINAL : 8'h00);
  end

endmodule

// File: rtl/shake_absorb_pad.sv
// Collects 64-bit message words into a SHAKE128/256 rate block, applies the
// SHAKE padding and hands each block to the permutation core.
module shake_absorb_pad
  import shake_pkg::*;
#(
  parameter int MAX_RATE_BITS = 1344,
  parameter int WORD_BITS     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [WORD_BITS-1:0]     in_data,
  input  logic                     in_last,
  input  logic [3:0]               in_bytes,
  output logic                     in_ready,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [MAX_RATE_BITS-1:0] blk_data,
  output logic                     blk_last,
  output logic                     blk_mode
);

  localparam int MAX_WORDS = MAX_RATE_BITS / WORD_BITS;

  state_e                              state_q, state_d;
  logic [MAX_WORDS-1:0][WORD_BITS-1:0] blk_buf_q, blk_buf_d;
  logic [4:0]                          word_cnt_q, word_cnt_d;
  logic [4:0]                          pad_ptr_q, pad_ptr_d;
  logic                                pad_pending_q, pad_pending_d;
  logic                                msg_active_q, msg_active_d;
  logic                                blk_last_q, blk_last_d;
  logic                                blk_mode_q, blk_mode_d;
  logic                                blk_valid_q, in_ready_q;

  logic                                accept_s, mode_eff_s, in_pad_s;
  logic [4:0]                          rate_last_s, gen_idx_s;
  logic [3:0]                          bytes_sat_s, gen_bytes_s;
  logic [63:0]                         gen_word_s, gen_out_s;

  // Mode is only taken from the port on the first word of a message.
  assign accept_s    = in_valid && (state_q == S_LOAD);
  assign mode_eff_s  = msg_active_q ? blk_mode_q : mode;
  assign rate_last_s = rate_words(mode_eff_s) - 5'd1;
  assign bytes_sat_s = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign in_pad_s    = (state_q == S_PAD);
  assign gen_idx_s   = in_pad_s ? pad_ptr_q : word_cnt_q;
  assign gen_word_s  = in_pad_s ? blk_buf_q[gen_idx_s] : in_data;
  assign gen_bytes_s = in_pad_s ? 4'd0 : bytes_sat_s;

  pad_word_gen u_pad_word_gen (
    .word_i              (gen_word_s),
    .bytes_i             (gen_bytes_s),
    .is_last_rate_word_i (gen_idx_s == rate_last_s),
    .insert_domain_i     (1'b1),
    .word_o              (gen_out_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (!accept_s) begin
          state_d = S_LOAD;
        end else if (!in_last) begin
          state_d = (word_cnt_q == rate_last_s) ? S_FULL : S_LOAD;
        end else if (bytes_sat_s != 4'd8) begin
          state_d = S_FULL;
        end else begin
          state_d = (word_cnt_q < rate_last_s) ? S_PAD : S_FULL;
        end
      end
      S_PAD:   state_d = S_FULL;
      S_FULL:  state_d = blk_ready ? (pad_pending_q ? S_PAD : S_LOAD) : S_FULL;
      default: state_d = S_LOAD;
    endcase
  end

  // Buffer and message bookkeeping next values.
  always_comb begin
    blk_buf_d     = blk_buf_q;
    word_cnt_d    = word_cnt_q;
    pad_ptr_d     = pad_ptr_q;
    pad_pending_d = pad_pending_q;
    msg_active_d  = msg_active_q;
    blk_last_d    = blk_last_q;
    blk_mode_d    = blk_mode_q;
    case (state_q)
      S_LOAD: begin
        if (!accept_s) begin
          msg_active_d = msg_active_q;
        end else if (in_last && (bytes_sat_s != 4'd8)) begin
          msg_active_d                  = 1'b1;
          blk_mode_d                    = mode_eff_s;
          blk_buf_d[word_cnt_q]         = gen_out_s;
          blk_buf_d[rate_last_s][63:56] = blk_buf_d[rate_last_s][63:56] | PAD_FINAL;
          blk_last_d                    = 1'b1;
        end else begin
          msg_active_d          = 1'b1;
          blk_mode_d            = mode_eff_s;
          blk_buf_d[word_cnt_q] = in_data;
          word_cnt_d    = (word_cnt_q != rate_last_s) ? word_cnt_q + 5'd1 : word_cnt_q;
          pad_ptr_d     = (in_last && (word_cnt_q < rate_last_s)) ? word_cnt_q + 5'd1 : pad_ptr_q;
          pad_pending_d = (in_last && (word_cnt_q == rate_last_s)) ? 1'b1 : pad_pending_q;
        end
      end
      S_PAD: begin
        blk_buf_d[pad_ptr_q]          = gen_out_s;
        blk_buf_d[rate_last_s][63:56] = blk_buf_d[rate_last_s][63:56] | PAD_FINAL;
        blk_last_d                    = 1'b1;
      end
      S_FULL: begin
        if (blk_ready) begin
          blk_buf_d     = '0;
          word_cnt_d    = 5'd0;
          blk_last_d    = 1'b0;
          msg_active_d  = blk_last_q ? 1'b0 : msg_active_q;
          pad_pending_d = 1'b0;
          pad_ptr_d     = pad_pending_q ? 5'd0 : pad_ptr_q;
        end else begin
          blk_buf_d = blk_buf_q;
        end
      end
      default: begin
        blk_buf_d = blk_buf_q;
      end
    endcase
  end

  // Datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_buf_q     <= '0;
      word_cnt_q    <= 5'd0;
      pad_ptr_q     <= 5'd0;
      pad_pending_q <= 1'b0;
      msg_active_q  <= 1'b0;
      blk_last_q    <= 1'b0;
      blk_mode_q    <= 1'b0;
      blk_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      blk_buf_q     <= blk_buf_d;
      word_cnt_q    <= word_cnt_d;
      pad_ptr_q     <= pad_ptr_d;
      pad_pending_q <= pad_pending_d;
      msg_active_q  <= msg_active_d;
      blk_last_q    <= blk_last_d;
      blk_mode_q    <= blk_mode_d;
      blk_valid_q   <= (state_d == S_FULL);
      in_ready_q    <= (state_d == S_LOAD);
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_buf_q;
  assign blk_last  = blk_last_q;
  assign blk_mode  = blk_mode_q;

endmodule

// File: tb/tb_shake_absorb_pad.sv
// Randomised bench for shake_absorb_pad: a byte-stream SHAKE padding model
// predicts every block, plus directed latency, backpressure and reset cases.
module tb_shake_absorb_pad;

  localparam int CW = 1344;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic          blk_valid;
  logic          blk_ready;
  logic [CW-1:0] blk_data;
  logic          blk_last;
  logic          blk_mode;

  typedef struct packed {
    logic [CW-1:0] data;
    logic          last;
    logic          mode;
  } blk_t;

  logic [63:0] words[$];
  blk_t        exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  shake_absorb_pad #(.MAX_RATE_BITS(1344), .WORD_BITS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_mode  (blk_mode)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_words(input int nw);
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
  endtask

  // Message bytes, then 0x1F, zero fill to a rate multiple, final byte |= 0x80.
  function automatic void model(input logic m, input int nw, input int lb);
    byte unsigned s[$];
    int rb, lc, nb, nblk;
    blk_t e;
    rb = m ? 136 : 168;
    lc = (lb > 8) ? 8 : lb;
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? lc : 8;
      for (int b = 0; b < nb; b++) s.push_back(words[w][8*b +: 8]);
    end
    s.push_back(8'h1F);
    while ((s.size() % rb) != 0) s.push_back(8'h00);
    s[s.size()-1] = s[s.size()-1] | 8'h80;
    nblk = s.size() / rb;
    for (int k = 0; k < nblk; k++) begin
      e.data = '0;
      for (int i = 0; i < rb; i++) e.data[8*i +: 8] = s[k*rb + i];
      e.last = (k == nblk - 1);
      e.mode = m;
      exp_q.push_back(e);
    end
  endfunction

  task automatic cmp_block(input string tag, input blk_t e);
    check_eq({tag, "_data"}, blk_data, e.data);
    check_eq({tag, "_last"}, CW'(blk_last), CW'(e.last));
    check_eq({tag, "_mode"}, CW'(blk_mode), CW'(e.mode));
  endtask

  // Back-to-back words, latency to blk_valid, 10-cycle stall, then drain.
  task automatic lat_case(input logic m, input int nw, input int lb, input int exp_lat, input string tag);
    int lat;
    logic [CW-1:0] snap;
    fill_words(nw);
    exp_q.delete();
    model(m, nw, lb);
    blk_ready = 1'b0;
    for (int i = 0; i < nw; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 4'(lb) : 4'd8;
      mode     = (i == 0) ? m : ~m;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq({tag, "_rdy_after_last"}, CW'(in_ready), CW'(0));
    lat = 1;
    while (!blk_valid && lat < 6) begin @(posedge clk); #1; lat++; end
    check_eq({tag, "_lat"}, CW'(lat), CW'(exp_lat));
    snap = blk_data;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      mode     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq({tag, "_stall_rdy"}, CW'({in_ready, blk_valid}), CW'(2'b01));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq({tag, "_stall_data"}, blk_data, snap);
    while (exp_q.size() > 0) begin
      cmp_block(tag, exp_q.pop_front());
      blk_ready = 1'b1;
      @(posedge clk); #1;
      blk_ready = 1'b0;
      if (exp_q.size() > 0) begin
        lat = 1;
        while (!blk_valid && lat < 6) begin @(posedge clk); #1; lat++; end
        check_eq({tag, "_padlat"}, CW'(lat), CW'(2));
      end
    end
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, CW'({blk_valid, in_ready}), CW'(2'b01));
  endtask

  // Random gaps on both handshakes; blocks compared at each handoff.
  task automatic run_msg(input logic m, input int nw, input int lb, input int pct);
    int wi, cyc;
    fill_words(nw);
    exp_q.delete();
    model(m, nw, lb);
    wi  = 0;
    cyc = 0;
    while ((wi < nw || exp_q.size() > 0) && cyc < 3000) begin
      in_valid  = (wi < nw) && ($urandom_range(0, 3) != 0);
      in_data   = (wi < nw) ? words[wi] : {$urandom, $urandom};
      in_last   = (wi == nw - 1);
      in_bytes  = (wi == nw - 1) ? 4'(lb) : 4'($urandom_range(0, 15));
      mode      = (wi == 0) ? m : 1'($urandom_range(0, 1));
      blk_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) check_eq("extra_block", CW'(1), CW'(0));
        else cmp_block("rnd", exp_q.pop_front());
      end
      if (in_valid && in_ready) wi++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rnd_msg_done", CW'((exp_q.size() == 0) && (wi == nw)), CW'(1));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
  endtask

  // Reset while a full block waits with a pad block still owed.
  task automatic reset_case();
    int lat;
    fill_words(17);
    blk_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == 16);
      in_bytes = 4'd8;
      mode     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 1;
    while (!blk_valid && lat < 6) begin @(posedge clk); #1; lat++; end
    check_eq("rst_pre_valid", CW'(blk_valid), CW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_mid_valid", CW'(blk_valid), CW'(0));
    check_eq("rst_mid_ready", CW'(in_ready), CW'(1));
    check_eq("rst_mid_data", blk_data, CW'(0));
    check_eq("rst_mid_last", CW'(blk_last), CW'(0));
    run_msg(1'b0, 2, 5, 100);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    in_last   = 1'b0;
    in_bytes  = 4'd0;
    blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", CW'(in_ready), CW'(1));
    check_eq("rst_blk_valid", CW'(blk_valid), CW'(0));
    check_eq("rst_blk_last", CW'(blk_last), CW'(0));
    check_eq("rst_blk_mode", CW'(blk_mode), CW'(0));
    check_eq("rst_blk_data", blk_data, CW'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    lat_case(1'b1, 17, 8, 1, "m1_full17");
    lat_case(1'b0, 1, 0, 1, "m0_empty");
    lat_case(1'b1, 17, 7, 1, "m1_b7");
    lat_case(1'b0, 3, 8, 2, "m0_midpad");
    lat_case(1'b0, 21, 3, 1, "m0_b3_last");
    reset_case();

    for (int t = 0; t < 40; t++) begin
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(1, 45)),
              int'($urandom_range(0, 10)), int'($urandom_range(30, 95)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
